// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared defaults, FSM state type and saturating step for STDP scheduling
package stdp_pkg;

  localparam int NUM_PRE = 4;
  localparam int TW      = 4;
  localparam int WW      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  // Result is formed one bit wider so carry/borrow out selects the clamp.
  function automatic logic [WW-1:0] sat_step(
    input logic [WW-1:0] w,
    input logic [WW-1:0] step,
    input logic          ltp
  );
    logic [WW:0] r;
    if (ltp) begin
      r        = {1'b0, w} + {1'b0, step};
      sat_step = r[WW] ? {WW{1'b1}} : r[WW-1:0];
    end else begin
      r        = {1'b0, w} - {1'b0, step};
      sat_step = r[WW] ? '0 : r[WW-1:0];
    end
  endfunction

endpackage

// File: rtl/stdp_rr_arb.sv
// rtl/stdp_rr_arb.sv - combinational round-robin pick: first set req at or after ptr, with wrap
module stdp_rr_arb #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = (int'(ptr) + k) % N;
      if (!gnt_any && req[pos]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/stdp_update_sched.sv
// rtl/stdp_update_sched.sv - STDP event capture, round-robin LTP/LTD scheduling, weight registers
module stdp_update_sched #(
  parameter int NUM_PRE  = stdp_pkg::NUM_PRE,
  parameter int TW       = stdp_pkg::TW,
  parameter int WW       = stdp_pkg::WW,
  parameter int WIN      = 8,
  parameter int LTP_STEP = 1,
  parameter int LTD_STEP = 1,
  parameter int W_INIT   = 8,
  localparam int IW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  learn_en,
  input  logic [NUM_PRE-1:0]    pre_spike,
  input  logic                  post_spike,
  input  logic [NUM_PRE*TW-1:0] pre_dt,
  input  logic [TW-1:0]         post_dt,
  output logic [NUM_PRE*WW-1:0] weight,
  output logic                  upd_valid,
  output logic [IW-1:0]         upd_idx,
  output logic                  upd_ltp,
  output logic                  busy
);

  import stdp_pkg::*;

  state_t               state, state_nx;
  logic [NUM_PRE-1:0]   pend, pol;
  logic [NUM_PRE-1:0]   cap_set, cap_pol, req_clr;
  logic [IW-1:0]        rr_ptr, idx, gnt_idx;
  logic                 gnt_any, act_pol, grant, apply;
  logic [NUM_PRE*WW-1:0] weight_q;

  // A post spike outranks a coincident pre spike: that pairing is LTP with dt = 0.
  always_comb begin
    cap_set = '0;
    cap_pol = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (learn_en) begin
        if (post_spike) begin
          if (pre_spike[i] || (32'(pre_dt[i*TW +: TW]) < WIN)) begin
            cap_set[i] = 1'b1;
            cap_pol[i] = 1'b1;
          end
        end else if (pre_spike[i] && (32'(post_dt) < WIN)) begin
          cap_set[i] = 1'b1;
        end
      end
    end
  end

  stdp_rr_arb #(.N(NUM_PRE)) u_arb (
    .req     (pend),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (learn_en && gnt_any) state_nx = APPLY;
      APPLY:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant   = (state == IDLE) && learn_en && gnt_any;
    apply   = (state == APPLY);
    busy    = (state != IDLE) || (|pend);
    req_clr = '0;
    if (grant) req_clr[gnt_idx] = 1'b1;
  end

  // Capture is OR-ed in after the grant clear, so a same-edge event keeps the channel pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= '0;
      pol       <= '0;
      rr_ptr    <= '0;
      idx       <= '0;
      act_pol   <= 1'b0;
      weight_q  <= {NUM_PRE{WW'(W_INIT)}};
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_ltp   <= 1'b0;
    end else begin
      pend      <= (pend & ~req_clr) | cap_set;
      pol       <= (pol & ~cap_set) | (cap_pol & cap_set);
      upd_valid <= apply;
      if (grant) begin
        idx     <= gnt_idx;
        act_pol <= pol[gnt_idx];
      end
      if (apply) begin
        weight_q[idx*WW +: WW] <= sat_step(weight_q[idx*WW +: WW],
                                           act_pol ? WW'(LTP_STEP) : WW'(LTD_STEP),
                                           act_pol);
        rr_ptr  <= (idx == IW'(NUM_PRE - 1)) ? '0 : idx + 1'b1;
        upd_idx <= idx;
        upd_ltp <= act_pol;
      end
    end
  end

  assign weight = weight_q;

endmodule

// File: tb/tb_stdp_update_sched.sv
// tb/tb_stdp_update_sched.sv - directed scoreboard bench for stdp_update_sched
module tb_stdp_update_sched;

  logic        clk = 1'b0;
  logic        rst_n, learn_en, post_spike;
  logic [3:0]  pre_spike, post_dt;
  logic [15:0] pre_dt, weight;
  logic        upd_valid, upd_ltp, busy;
  logic [1:0]  upd_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k;
  int wm[4];

  typedef struct {
    int          cyc;
    int          idx;
    logic        ltp;
    logic [15:0] w;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  stdp_update_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .learn_en   (learn_en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .pre_dt     (pre_dt),
    .post_dt    (post_dt),
    .weight     (weight),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_ltp    (upd_ltp),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] packw();
    return {4'(wm[3]), 4'(wm[2]), 4'(wm[1]), 4'(wm[0])};
  endfunction

  task automatic expect_upd(input int at, input int ch, input logic ltp);
    exp_t e;
    if (ltp) wm[ch] = (wm[ch] >= 15) ? 15 : wm[ch] + 1;
    else     wm[ch] = (wm[ch] <= 0)  ? 0  : wm[ch] - 1;
    e.cyc = at;
    e.idx = ch;
    e.ltp = ltp;
    e.w   = packw();
    sbq.push_back(e);
  endtask

  // One clock edge, then inspect outputs 1 time unit later and score any update.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (upd_valid === 1'b1) begin
      chk("sb_has_entry", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("upd_cycle", cyc, e.cyc);
        chk("upd_idx", 32'(upd_idx), e.idx);
        chk("upd_ltp", 32'(upd_ltp), 32'(e.ltp));
        chk("weight_after_upd", 32'(weight), 32'(e.w));
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      chk("upd_valid_due", 32'(upd_valid), 1);
      void'(sbq.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) wm[i] = 8;
    rst_n = 1'b0; learn_en = 1'b0; post_spike = 1'b0;
    pre_spike = 4'h0; post_dt = 4'hF; pre_dt = 16'hFFFF;

    ticks(2);
    rst_n = 1'b1;
    chk("reset_weight", 32'(weight), 32'h8888);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_upd_valid", 32'(upd_valid), 0);
    chk("reset_upd_idx", 32'(upd_idx), 0);
    chk("reset_upd_ltp", 32'(upd_ltp), 0);

    learn_en = 1'b1;
    post_spike = 1'b1; pre_dt = 16'h7093;
    k = cyc + 1;
    expect_upd(k + 2, 0, 1);
    expect_upd(k + 4, 2, 1);
    expect_upd(k + 6, 3, 1);
    tick();
    post_spike = 1'b0;
    chk("fanout_busy", 32'(busy), 1);
    ticks(8);
    chk("fanout_weight", 32'(weight), 32'h9989);
    chk("fanout_idle", 32'(busy), 0);

    pre_spike = 4'b0010; post_dt = 4'd2;
    k = cyc + 1;
    expect_upd(k + 2, 1, 0);
    tick();
    pre_spike = 4'b0000;
    ticks(4);
    chk("ltd_weight", 32'(weight), 32'h9979);

    pre_spike = 4'b0010; post_dt = 4'd8;
    tick();
    pre_spike = 4'b0000;
    chk("ltd_outside_window_busy", 32'(busy), 0);
    ticks(3);
    chk("ltd_outside_window_weight", 32'(weight), 32'h9979);

    pre_dt = 16'hFFF0;
    for (int n = 0; n < 7; n++) begin
      post_spike = 1'b1;
      k = cyc + 1;
      expect_upd(k + 2, 0, 1);
      tick();
      post_spike = 1'b0;
      ticks(2);
    end
    chk("sat_high_ch0", 32'(weight[3:0]), 15);

    post_dt = 4'd2;
    for (int n = 0; n < 16; n++) begin
      pre_spike = 4'b0001;
      k = cyc + 1;
      expect_upd(k + 2, 0, 0);
      tick();
      pre_spike = 4'b0000;
      ticks(2);
    end
    chk("sat_low_ch0", 32'(weight[3:0]), 0);

    pre_spike = 4'b1000;
    k = cyc + 1;
    expect_upd(k + 2, 3, 0);
    tick();
    pre_spike = 4'b0000;
    ticks(3);

    post_spike = 1'b1; pre_dt = 16'h0FF0;
    k = cyc + 1;
    for (int n = 0; n < 6; n++) expect_upd(k + 2 + 2 * n, (n % 2 == 0) ? 0 : 3, 1);
    ticks(8);
    post_spike = 1'b0;
    ticks(8);
    chk("fair_weight", 32'(weight), 32'(packw()));
    chk("fair_idle", 32'(busy), 0);

    pre_spike = 4'b0101; post_dt = 4'd2;
    k = cyc + 1;
    expect_upd(k + 2, 0, 0);
    expect_upd(k + 4, 2, 1);
    tick();
    pre_spike = 4'b0000; post_spike = 1'b1; pre_dt = 16'hF0FF;
    tick();
    post_spike = 1'b0;
    ticks(6);
    chk("overwrite_idle", 32'(busy), 0);

    post_spike = 1'b1; pre_dt = 16'hFF0F;
    k = cyc + 1;
    tick();
    post_spike = 1'b0; learn_en = 1'b0;
    ticks(3);
    chk("hold_pend_busy", 32'(busy), 1);
    learn_en = 1'b1;
    expect_upd(k + 5, 1, 1);
    ticks(4);
    chk("hold_resume_idle", 32'(busy), 0);

    post_spike = 1'b1; pre_dt = 16'h0000;
    tick();
    post_spike = 1'b0;
    tick();
    chk("apply_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) wm[i] = 8;
    chk("midreset_weight", 32'(weight), 32'h8888);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_upd_valid", 32'(upd_valid), 0);
    chk("midreset_upd_idx", 32'(upd_idx), 0);
    rst_n = 1'b1;
    ticks(6);
    chk("post_reset_weight", 32'(weight), 32'h8888);
    chk("post_reset_busy", 32'(busy), 0);
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
